// File: rtl/mac_result_bcd_converter.sv
// Sequential shift-and-add-3 binary-to-BCD converter for the MAC result.
// Shifts one bit per clock; the last result is held stable for the HEX displays.
module mac_result_bcd_converter #(
    parameter int BIN_W  = 17,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int CW = $clog2(BIN_W + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state, state_nx;
    logic [BIN_W-1:0]    bin_sr, bin_nx;
    logic [4*DIGITS-1:0] scratch, scratch_nx, adj, shifted, bcd_nx;
    logic                ovf_scr, ovf_scr_nx, ovf_nx, done_nx;
    logic [CW-1:0]       count, count_nx;

    // Add 3 to every digit >= 5, then shift the binary MSB into digit 0.
    always_comb begin
        adj = scratch;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
        shifted = {adj[4*DIGITS-2:0], bin_sr[BIN_W-1]};
    end

    always_comb begin
        state_nx   = state;
        bin_nx     = bin_sr;
        scratch_nx = scratch;
        ovf_scr_nx = ovf_scr;
        count_nx   = count;
        done_nx    = 1'b0;
        bcd_nx     = bcd_out;
        ovf_nx     = overflow;
        case (state)
            IDLE: begin
                if (start) begin
                    bin_nx     = bin_in;
                    scratch_nx = '0;
                    ovf_scr_nx = 1'b0;
                    count_nx   = CW'(BIN_W);
                    state_nx   = SHIFT;
                end
            end
            SHIFT: begin
                bin_nx     = bin_sr << 1;
                scratch_nx = shifted;
                // A bit leaving the top digit means the value needs more digits.
                ovf_scr_nx = ovf_scr | adj[4*DIGITS-1];
                count_nx   = count - CW'(1);
                if (count == CW'(1)) begin
                    bcd_nx   = shifted;
                    ovf_nx   = ovf_scr_nx;
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            bin_sr   <= '0;
            scratch  <= '0;
            ovf_scr  <= 1'b0;
            count    <= '0;
            done     <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nx;
            bin_sr   <= bin_nx;
            scratch  <= scratch_nx;
            ovf_scr  <= ovf_scr_nx;
            count    <= count_nx;
            done     <= done_nx;
            bcd_out  <= bcd_nx;
            overflow <= ovf_nx;
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_mac_result_bcd_converter.sv
// Directed, table-driven bench for mac_result_bcd_converter (default and 8-bit/2-digit instances).
module tb_mac_result_bcd_converter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [16:0] bin_in = '0;
    logic        busy, done, overflow;
    logic [23:0] bcd_out;

    logic        start_s = 1'b0;
    logic [7:0]  bin_s = '0;
    logic        busy_s, done_s, ovf_s;
    logic [7:0]  bcd_s;

    int n_cmp = 0;
    int n_err = 0;
    int n_ovl = 0;
    int n_done = 0;

    mac_result_bcd_converter dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow)
    );

    mac_result_bcd_converter #(.BIN_W(8), .DIGITS(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .bin_in(bin_s),
        .busy(busy_s), .done(done_s), .bcd_out(bcd_s), .overflow(ovf_s)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done && busy) n_ovl++;
        if (done_s && busy_s) n_ovl++;
        if (done) n_done++;
    end

    typedef struct {
        logic [16:0] bin;
        logic [23:0] bcd;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [7:0] bin;
        logic [7:0] bcd;
        logic       ovf;
    } vec_s_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at #1 after a posedge with the DUT idle; returns at #1 after the done edge.
    task automatic conv(input logic [16:0] v, output logic [23:0] bcd, output logic ovf,
                        output int lat, output int nb);
        bin_in = v;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        nb  = 0;
        while (!done && lat < 100) begin
            if (busy) nb++;
            @(posedge clk); #1;
            lat++;
        end
        bcd = bcd_out;
        ovf = overflow;
    endtask

    task automatic conv_s(input logic [7:0] v, output logic [7:0] bcd, output logic ovf,
                          output int lat);
        bin_s   = v;
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        lat = 0;
        while (!done_s && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        bcd = bcd_s;
        ovf = ovf_s;
    endtask

    initial begin
        vec_t   vt[9];
        vec_s_t vs[5];
        logic [23:0] r;
        logic [7:0]  rs;
        logic        o;
        int          lat, nb, d0;

        vt[0] = '{17'd0,      24'h000000, 1'b0};
        vt[1] = '{17'd130050, 24'h130050, 1'b0};
        vt[2] = '{17'd99999,  24'h099999, 1'b0};
        vt[3] = '{17'd100000, 24'h100000, 1'b0};
        vt[4] = '{17'd9,      24'h000009, 1'b0};
        vt[5] = '{17'd10,     24'h000010, 1'b0};
        vt[6] = '{17'd65535,  24'h065535, 1'b0};
        vt[7] = '{17'd131071, 24'h131071, 1'b0};
        vt[8] = '{17'd12345,  24'h012345, 1'b0};

        vs[0] = '{8'd255, 8'h55, 1'b1};
        vs[1] = '{8'd99,  8'h99, 1'b0};
        vs[2] = '{8'd100, 8'h00, 1'b1};
        vs[3] = '{8'd0,   8'h00, 1'b0};
        vs[4] = '{8'd42,  8'h42, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_bcd", {8'b0, bcd_out}, 32'd0);
        check("reset_ovf", {31'b0, overflow}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vt[i]) begin
            conv(vt[i].bin, r, o, lat, nb);
            check($sformatf("lat_%0d", vt[i].bin), lat, 32'd17);
            check($sformatf("bcd_%0d", vt[i].bin), {8'b0, r}, {8'b0, vt[i].bcd});
            check($sformatf("ovf_%0d", vt[i].bin), {31'b0, o}, {31'b0, vt[i].ovf});
            if (i == 0) check("busy_cycles", nb, 32'd17);
            @(posedge clk); #1;
        end

        // Second start mid-conversion must be ignored; previous result held meanwhile.
        d0 = n_done;
        bin_in = 17'd12345;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            if (lat == 5) begin
                check("hold_mid_conv", {8'b0, bcd_out}, 32'h012345);
                bin_in = 17'd500;
                start  = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check("ign_lat", lat, 32'd17);
        check("ign_bcd", {8'b0, bcd_out}, 32'h012345);
        repeat (20) @(posedge clk);
        #1;
        check("ign_one_done", n_done - d0, 32'd1);
        check("ign_hold", {8'b0, bcd_out}, 32'h012345);

        // Reset in the middle of a conversion.
        d0 = n_done;
        bin_in = 17'd777;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_bcd", {8'b0, bcd_out}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_done", n_done - d0, 32'd0);
        conv(17'd42, r, o, lat, nb);
        check("after_abort_bcd", {8'b0, r}, 32'h000042);
        check("after_abort_lat", lat, 32'd17);
        @(posedge clk); #1;

        // start held high: each done cycle's start is accepted on the following edge.
        start = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            bin_in = 17'(k);
            @(posedge clk); #1;
            check($sformatf("b2b_accept_%0d", k), {31'b0, busy}, 32'd1);
            lat = 0;
            while (!done && lat < 100) begin
                @(posedge clk); #1;
                lat++;
            end
            check($sformatf("b2b_lat_%0d", k), lat, 32'd17);
            check($sformatf("b2b_bcd_%0d", k), {8'b0, bcd_out}, 32'(k));
        end
        start = 1'b0;
        @(posedge clk); #1;
        check("b2b_idle", {31'b0, busy}, 32'd0);

        foreach (vs[i]) begin
            conv_s(vs[i].bin, rs, o, lat);
            check($sformatf("s_lat_%0d", vs[i].bin), lat, 32'd8);
            check($sformatf("s_bcd_%0d", vs[i].bin), {24'b0, rs}, {24'b0, vs[i].bcd});
            check($sformatf("s_ovf_%0d", vs[i].bin), {31'b0, o}, {31'b0, vs[i].ovf});
            @(posedge clk); #1;
        end

        check("done_busy_overlap", n_ovl, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
